ftdi_rx_fifo: RTL

Receive-side buffer downstream of `ftdiController`. It takes bytes from the controller's 4-phase rx handshake (`out_rx_hsk_req`/`in_rx_hsk_ack`/`out_rx_data`) and stores them in a first-word-fall-through FIFO. It presents them to user logic on a valid/ready stream. It also drives the controller's `in_rx_en` so that FT2232H reads pause before the FIFO can overflow.

---
 rtl/ftdi_rx_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/ftdi_rx_fifo.sv
// Receive buffer behind ftdiController: 4-phase rx handshake into a FWFT FIFO with valid/ready output.
// Optional statistics counters are built when FTDI_RX_FIFO_STATS_EN is defined.
module ftdi_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     in_rx_hsk_req,
  input  logic [7:0]               in_rx_data,
  output logic                     out_rx_hsk_ack,
  output logic                     out_rx_en,
  input  logic                     in_flush,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     in_ready,
  output logic [$clog2(DEPTH):0]   out_level,
  output logic [15:0]              out_byte_count,
  output logic [7:0]               out_drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(DEPTH - AFULL_MARGIN);

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  state_t          state, state_nx;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level, level_nx;
  logic            push, push_st, pop;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      IDLE: if (in_rx_hsk_req && (level < FULL_LVL)) begin
        push     = 1'b1;
        state_nx = WAIT_LOW;
      end
      WAIT_LOW: if (!in_rx_hsk_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A push during flush still completes the handshake but is not stored.
  assign push_st   = push & ~in_flush;
  assign pop       = out_valid & in_ready & ~in_flush;
  assign level_nx  = in_flush ? '0 : level + LW'(push_st) - LW'(pop);

  assign out_valid      = (level != '0);
  assign out_data       = out_valid ? mem[rd_ptr] : 8'h00;
  assign out_level      = level;
  assign out_rx_hsk_ack = (state == WAIT_LOW);

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_rx_en <= 1'b0;
    end else begin
      state     <= state_nx;
      level     <= level_nx;
      out_rx_en <= (level_nx < AFULL_LVL);
      if (in_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_st) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (push_st) mem[wr_ptr] <= in_rx_data;
  end

`ifdef FTDI_RX_FIFO_STATS_EN
  logic [9:0] drop_sum;
  assign drop_sum = {2'b00, out_drop_count}
                  + (in_flush ? 10'(level) : 10'd0)
                  + 10'(push & in_flush);

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      out_byte_count <= '0;
      out_drop_count <= '0;
    end else begin
      if (push) out_byte_count <= out_byte_count + 16'd1;
      out_drop_count <= (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end
  end
`else
  assign out_byte_count = '0;
  assign out_drop_count = '0;
`endif
endmodule
